// File: rtl/conv_kxk_stream_if.sv
// conv_kxk_stream_if: valid/ready pixel stream (dstream) carrying one W-bit pixel.
//   data  : pixel, CH fields of CW bits, channel 0 at the LSBs
//   valid : producer has a pixel on data
//   ready : consumer takes data on this edge when valid is also high
// master drives data/valid, slave drives ready.
interface conv_kxk_stream_if #(parameter int W = 30);
  logic [W-1:0] data;
  logic         valid;
  logic         ready;

  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
endinterface

// File: rtl/conv_kxk_stream.sv
// conv_kxk_stream: centred KxK RGB convolution on a raster-scan pixel stream.
//   clk, reset   : clock, asynchronous active-high reset
//   x            : input pixel stream (slave)
//   y            : output pixel stream (master), one output per input pixel
//   coef_we/addr/data : runtime kernel write, row-major taps, 0 = top-left
//   shift        : arithmetic right shift applied to each channel sum
//   border_mode  : 0 = zero-pad out-of-image taps, 1 = border pixels pass through
//   frame_done   : pulses with the y transfer of the last output of a frame
// The first D = P*IMG_W+P inputs only prime the line buffers; the frame is
// then finished by D drain advances that shift in zeros, so every input pixel
// yields exactly one output.
module conv_kxk_stream #(
  parameter int IMG_W = 320,
  parameter int IMG_H = 240,
  parameter int K     = 5,
  parameter int CH    = 3,
  parameter int CW    = 10,
  parameter int BW    = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  conv_kxk_stream_if.slave         x,
  conv_kxk_stream_if.master        y,
  input  logic                     coef_we,
  input  logic [$clog2(K*K)-1:0]   coef_addr,
  input  logic signed [BW-1:0]     coef_data,
  input  logic [2:0]               shift,
  input  logic                     border_mode,
  output logic                     frame_done
);
  localparam int W   = CH*CW;
  localparam int P   = (K-1)/2;
  localparam int N   = IMG_W*IMG_H;
  localparam int D   = P*IMG_W + P;
  localparam int SW  = 9 + BW + $clog2(K*K);
  localparam int NCW = $clog2(N);
  localparam int XW  = $clog2(IMG_W);
  localparam int YW  = $clog2(IMG_H);

  localparam logic [NCW-1:0] IN_LAST   = NCW'(N-1);
  localparam logic [NCW-1:0] FILL_LAST = NCW'(D-1);
  localparam logic [XW-1:0]  X_LAST    = XW'(IMG_W-1);
  localparam logic [YW-1:0]  Y_LAST    = YW'(IMG_H-1);
  localparam logic [XW-1:0]  X_LO      = XW'(P);
  localparam logic [XW-1:0]  X_HI      = XW'(IMG_W-P);
  localparam logic [YW-1:0]  Y_LO      = YW'(P);
  localparam logic [YW-1:0]  Y_HI      = YW'(IMG_H-P);
  localparam logic signed [SW-1:0] SAT = SW'(255);

  typedef enum logic [1:0] {FILL, RUN, DRAIN} state_t;
  state_t state, state_n;

  logic [NCW-1:0] in_cnt;   // inputs accepted this frame
  logic [XW-1:0]  wptr;     // line-buffer column, free-running mod IMG_W
  logic [YW-1:0]  cr;       // centre row of the next output
  logic [XW-1:0]  cc;       // centre column of the next output
  logic           y_last;
  logic [K*K-1:0][BW-1:0] coef;

  // lb[0] is the line just above the incoming pixel; each lb stage is an IMG_W delay.
  logic [W-1:0] lb [K-1][IMG_W];
  // win[j][i]: column j (K-1 = newest), row i (0 = oldest line)
  logic [K-1:0][K-1:0][W-1:0] win, nwin;
  logic [K-1:0][W-1:0] newcol;
  logic [W-1:0] newpx, conv_px, pt_px, out_px;
  logic [K-1:0] rv, cv;
  logic x_rdy, adv, emit, last_in, last_out, is_border;

  always_comb begin
    x_rdy    = (state != DRAIN) && (!y.valid || y.ready);
    adv      = (state == DRAIN) ? (!y.valid || y.ready) : (x.valid && x_rdy);
    emit     = adv && (state != FILL);
    last_in  = (in_cnt == IN_LAST);
    last_out = (cr == Y_LAST) && (cc == X_LAST);
    state_n  = state;
    case (state)
      FILL:  if (adv) begin
               if (last_in)                         state_n = DRAIN;
               else if (D < N && in_cnt == FILL_LAST) state_n = RUN;
             end
      RUN:   if (adv && last_in)  state_n = DRAIN;
      DRAIN: if (adv && last_out) state_n = FILL;
      default:                    state_n = FILL;
    endcase
  end

  assign x.ready    = x_rdy;
  assign frame_done = y.valid && y.ready && y_last;

  // Window after this advance: shift left, new column from line buffers + new pixel.
  always_comb begin
    newpx = (state == DRAIN) ? '0 : x.data;
    for (int i = 0; i < K-1; i++) newcol[i] = lb[K-2-i][wptr];
    newcol[K-1] = newpx;
    for (int j = 0; j < K-1; j++) nwin[j] = win[j+1];
    nwin[K-1] = newcol;
  end

  // Tap validity from the centre coordinates only; buffer contents are never trusted.
  always_comb begin
    int rr, cx;
    rv = '0;
    cv = '0;
    for (int i = 0; i < K; i++) begin
      rr = int'(cr) + i - P;
      cx = int'(cc) + i - P;
      rv[i] = (rr >= 0) && (rr < IMG_H);
      cv[i] = (cx >= 0) && (cx < IMG_W);
    end
  end

  assign is_border = (cr < Y_LO) || (cr >= Y_HI) || (cc < X_LO) || (cc >= X_HI);

  for (genvar ch = 0; ch < CH; ch++) begin : g_ch
    logic signed [SW-1:0] acc, sh;
    logic [7:0] val;
    always_comb begin
      acc = '0;
      for (int i = 0; i < K; i++)
        for (int j = 0; j < K; j++)
          if (rv[i] && cv[j])
            acc = acc + $signed({{(SW-8){1'b0}}, nwin[j][i][ch*CW+CW-8 +: 8]})
                      * $signed({{(SW-BW){coef[i*K+j][BW-1]}}, coef[i*K+j]});
      sh = acc >>> shift;
      if (sh[SW-1])      val = 8'd0;
      else if (sh > SAT) val = 8'hff;
      else               val = sh[7:0];
    end
    assign conv_px[ch*CW +: CW] = CW'(val) << (CW-8);
    assign pt_px[ch*CW +: CW]   = CW'(nwin[P][P][ch*CW+CW-8 +: 8]) << (CW-8);
  end

  assign out_px = (border_mode && is_border) ? pt_px : conv_px;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= FILL;
      in_cnt  <= '0;
      wptr    <= '0;
      cr      <= '0;
      cc      <= '0;
      y_last  <= 1'b0;
      y.valid <= 1'b0;
      y.data  <= '0;
      for (int t = 0; t < K*K; t++) coef[t] <= (t == (K*K)/2) ? BW'(1) : '0;
    end else begin
      state <= state_n;
      if (coef_we && int'(coef_addr) < K*K) coef[coef_addr] <= coef_data;
      if (adv) wptr <= (wptr == X_LAST) ? '0 : wptr + 1'b1;
      if (adv && state != DRAIN) in_cnt <= last_in ? '0 : in_cnt + 1'b1;
      if (emit) begin
        y.data <= out_px;
        y_last <= last_out;
        cc     <= (cc == X_LAST) ? '0 : cc + 1'b1;
        if (cc == X_LAST) cr <= (cr == Y_LAST) ? '0 : cr + 1'b1;
      end
      if (emit)         y.valid <= 1'b1;
      else if (y.ready) y.valid <= 1'b0;
    end
  end

  // Line buffers and window hold data only; they need no reset.
  always_ff @(posedge clk) begin
    if (adv) begin
      win <= nwin;
      lb[0][wptr] <= newpx;
      for (int l = 1; l < K-1; l++) lb[l][wptr] <= lb[l-1][wptr];
    end
  end
endmodule
